// File: rtl/fsm_pkg.sv
// Shared definitions for the 1-0-1-0 serial pattern detector.
// The state encoding is visible on the debug port, so it is fixed here.
package fsm_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

endpackage

// File: rtl/fsm.sv
// Overlapping 1-0-1-0 sequence detector with a Mealy detect flag and the raw state register exposed.
// Z2 fires combinationally while the state holds "101" and the current bit is the closing 0.
module fsm
    import fsm_pkg::*;
(
    input  logic       Clk,
    input  logic       Clr,
    input  logic       X,
    output logic       Z2,
    output logic [1:0] state1
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    // From S3 a 0 falls back to S2 so the trailing "10" starts the next match.
    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = X ? S1 : S0;
            S1:      w_next = X ? S1 : S2;
            S2:      w_next = X ? S3 : S0;
            S3:      w_next = X ? S1 : S2;
            default: w_next = S0;
        endcase
    end

    always_comb begin
        Z2 = (r_state == S3) && !X && Clr;
    end

    assign state1 = r_state;

endmodule

// File: tb/tb_fsm.sv
// Scoreboard bench for fsm: stimulus pushes hand-computed {state1, Z2} expectations,
// an independent monitor pops and compares one entry per sample request.
module tb_fsm;

    logic       Clk;
    logic       Clr;
    logic       X;
    logic       Z2;
    logic [1:0] state1;

    typedef struct {
        logic [1:0] st;
        logic       z;
        string      name;
    } expect_t;

    expect_t expQ[$];
    event    sampleReq;
    int      testsRun;
    int      testsFailed;

    fsm dut (
        .Clk    (Clk),
        .Clr    (Clr),
        .X      (X),
        .Z2     (Z2),
        .state1 (state1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive inputs on the falling edge and queue what the outputs must show before the next rising edge.
    task automatic applyStimulus(input logic clr, input logic x,
                                 input logic [1:0] expSt, input logic expZ, input string name);
        expect_t e;
        @(negedge Clk);
        Clr = clr;
        X   = x;
        e.st = expSt;
        e.z  = expZ;
        e.name = name;
        expQ.push_back(e);
        -> sampleReq;
    endtask

    // Pull reset low between edges and expect the outputs to clear without any clock edge.
    task automatic applyAsyncReset(input string name);
        expect_t e;
        #3;
        Clr = 1'b0;
        e.st = 2'b00;
        e.z  = 1'b0;
        e.name = name;
        expQ.push_back(e);
        -> sampleReq;
    endtask

    task automatic checkOutput(input expect_t e);
        testsRun++;
        if (state1 !== e.st || Z2 !== e.z) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual state1=%b Z2=%b, required state1=%b Z2=%b",
                     e.name, state1, Z2, e.st, e.z);
        end
    endtask

    initial begin
        expect_t e;
        forever begin
            @(sampleReq);
            #1;
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL scoreboard: actual=empty queue required=pending entry");
            end else begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        Clr = 1'b0;
        X   = 1'b0;

        // Held in reset with X toggling.
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, "rst0");
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, "rst1");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, "rst2");
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, "rst3");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, "rst4");

        // Release, then 0,1,0,1 walks S0,S1,S2,S3; the closing 0 raises Z2 before the edge.
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, "rel_x0");
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, "walk_s0");
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, "walk_s1");
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, "walk_s2");
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b1, "detect1");
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, "after_detect");

        // S3 with X=1 goes to S1.
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, "s3_x1");
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, "s3_to_s1");
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, "s1_x0");
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, "s2_x0");
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, "s0_x0");

        // Non-match stream 1,1,0,0 from S0.
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, "nm_a");
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, "nm_b");
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, "nm_c");
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, "nm_d");

        // Overlapping stream 1,0,1,0,1,0 from S0.
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, "ov1");
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, "ov2");
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, "ov3");
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b1, "ov4_detect");
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, "ov5");
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b1, "ov6_detect");
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, "ov_end_s2");

        // Asynchronous reset while Z2 is high.
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b1, "pre_async");
        applyAsyncReset("async_clear");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, "async_held");
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, "async_rel");
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, "post_rel_s1");

        repeat (3) @(negedge Clk);
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: actual=%0d pending entries required=0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fsm.md
Name: fsm

Overview:
- Serial sequence detector. Samples 1-bit input X on every rising Clk edge.
- Flags each occurrence of the bit pattern 1-0-1-0 on X. Overlapping occurrences are detected.
- Exposes its current 2-bit state for debug/observation.
- Leaf control block placed directly on a serial bit stream. Single clock domain.

Parameters:
- None. Pattern, encoding and widths are fixed.

Ports:
- Clk     input   1  system clock; all state updates on the rising edge.
- Clr     input   1  reset. One clock; reset is asynchronous and active-low. Clr=0 forces the state to S0 immediately.
- X       input   1  serial data bit, sampled on the rising Clk edge.
- Z2      output  1  detect flag (Mealy). High while the last three sampled bits are 1,0,1 and the current X is 0.
- state1  output  2  current state register value (encoding below).

Behaviour:
- Four states, binary encoded:
  - S0=2'b00: idle / no useful prefix.
  - S1=2'b01: seen "1".
  - S2=2'b10: seen "10".
  - S3=2'b11: seen "101".
- Reset:
  - While Clr=0, state=S0 asynchronously, regardless of Clk.
  - Consequently state1=00 and Z2=0.
  - Release of Clr is taken on the next rising edge. No glitch on state1 at release.
- Next-state on rising Clk, when Clr=1:
  - S0: X=1 -> S1; X=0 -> S0.
  - S1: X=1 -> S1; X=0 -> S2.
  - S2: X=1 -> S3; X=0 -> S0.
  - S3: X=1 -> S1; X=0 -> S2 (overlap: the trailing "10" is reused).
- Output Z2 (Mealy, combinational):
  - Z2 = (state==S3) && (X==0) && Clr.
  - Z2 asserts in the same cycle X presents the final 0, before the clock edge that consumes it.
  - Zero-cycle latency from X to Z2. Z2 falls when the state leaves S3 or X returns to 1.
- state1 output:
  - Driven directly from the state register, so it is glitch-free.
  - Updates one Clk-to-Q after each rising edge.
- Unused encodings: none; all 4 codes are legal.
- Defensive default: any unknown or X state value recovers to S0 on the next edge.
- Reset mid-sequence: Clr=0 at any time discards partial progress. Z2 drops to 0 at once.
- X should change away from the rising edge (e.g. on falling edges). Setup/hold is the normal flop requirement.

Decomposition:
- Shared package fsm_pkg: state typedef (enum logic [1:0] {S0,S1,S2,S3}) with the encodings above.
- Single module. No sub-module.
- Internal structure:
  - one always_ff with async negedge Clr for the state register;
  - one always_comb for next-state and the Z2 decode.

Test Plan:
- Hold Clr=0 while toggling X and Clk for 5 cycles -> state1=00 and Z2=0 throughout.
- Release Clr=1, then X=0,1,0,1 on successive falling edges -> after the rising edges state1 = 00,01,10,11.
- Next, drive X=0 -> Z2=1 before the following edge; after that edge state1=10 and Z2=0.
- Overlap: X stream 1,0,1,0,1,0 -> Z2 pulses twice, in the cycles holding the 4th and 6th bits; state1 ends at 10.
- Non-match paths:
  - X=1,1,0,0 -> state1 = 01,01,10,00, Z2 never high.
  - From S3, X=1 -> state1=01.
- Async reset mid-run: in S3 with X=0 (Z2=1), pull Clr=0 between edges -> state1=00 and Z2=0 immediately, without waiting for a clock edge.
